// File: rtl/axi_lite_arb_pkg.sv
// axi_lite_arb_pkg: shared widths, FSM states and round-robin ring slot encoding
package axi_lite_arb_pkg;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;

    // Ring slot: bit 1 selects the requester, bit 0 the access type (flipped by RD_FIRST)
    typedef logic [1:0] slot_t;
    localparam slot_t LAST_SLOT = 2'd3;

    function automatic logic slot_src(input slot_t s);
        return s[1];
    endfunction

    function automatic logic slot_rd(input slot_t s, input bit rd_first);
        return s[0] ^ rd_first;
    endfunction

    function automatic logic [3:0] rd_mask(input bit rd_first);
        return rd_first ? 4'b0101 : 4'b1010;
    endfunction
endpackage

// File: rtl/axi_lite_bus_t.sv
// axi_lite_bus_t: AXI-lite signal bundle; master modport faces a requester, slave modport faces the target
interface axi_lite_bus_t;
    import axi_lite_arb_pkg::*;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    modport master (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/rr_arb4.sv
// rr_arb4: 4-way rotating-priority arbiter, one-hot grant, pointer moves to the winner on upd
module rr_arb4
    import axi_lite_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       upd,
    output logic [3:0] gnt
);
    slot_t ptr, idx, c;

    // Pick the first requesting slot after ptr; scanning downward lets the nearest one win
    always_comb begin
        idx = ptr;
        c = '0;
        for (int i = 4; i >= 1; i--) begin
            c = ptr + 2'(i);
            if (req[c]) idx = c;
        end
        gnt = |req ? 4'b0001 << idx : 4'b0000;
    end

    // Pointer starts on the last slot so slot 0 has top priority after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= LAST_SLOT;
        else if (upd && |req) ptr <= idx;
    end
endmodule

// File: rtl/axi_lite_arb_2x1.sv
// axi_lite_arb_2x1: two AXI-lite requesters share one target, one transaction at a time, round-robin
module axi_lite_arb_2x1
    import axi_lite_arb_pkg::*;
#(
    parameter bit RD_FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    axi_lite_bus_t.master s0,
    axi_lite_bus_t.master s1,
    axi_lite_bus_t.slave  m,
    output logic          busy
);
    state_t state, state_n;
    logic gsrc, gsrc_n, aw_done, w_done, awd_n, wd_n, upd, g_src, g_rd;
    logic [3:0] req, gnt;
    logic [1:0] wr, rd;
    logic in_w, in_b, in_ar, in_r;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic awready_g, wready_g, bvalid_g, arready_g, rvalid_g;
    logic [AW-1:0] src_awaddr, src_araddr;
    logic [DW-1:0] src_wdata;
    logic [SW-1:0] src_wstrb;
    logic src_awvalid, src_wvalid, src_bready, src_arvalid, src_rready;

    assign wr = {s1.awvalid & s1.wvalid, s0.awvalid & s0.wvalid};
    assign rd = {s1.arvalid, s0.arvalid};

    // Map each requester's candidates onto the ring slots
    always_comb begin
        req = '0;
        for (int k = 0; k < 4; k++)
            req[k] = slot_rd(slot_t'(k), RD_FIRST) ? rd[slot_src(slot_t'(k))] : wr[slot_src(slot_t'(k))];
    end

    rr_arb4 u_arb (.clk(clk), .rst_n(rst_n), .req(req), .upd(upd), .gnt(gnt));

    assign g_src = |gnt[3:2];
    assign g_rd  = |(gnt & rd_mask(RD_FIRST));

    assign in_w  = state == WADDR;
    assign in_b  = state == WRESP;
    assign in_ar = state == RADDR;
    assign in_r  = state == RDATA;
    assign busy  = state != IDLE;

    assign src_awaddr  = gsrc ? s1.awaddr  : s0.awaddr;
    assign src_awvalid = gsrc ? s1.awvalid : s0.awvalid;
    assign src_wdata   = gsrc ? s1.wdata   : s0.wdata;
    assign src_wstrb   = gsrc ? s1.wstrb   : s0.wstrb;
    assign src_wvalid  = gsrc ? s1.wvalid  : s0.wvalid;
    assign src_bready  = gsrc ? s1.bready  : s0.bready;
    assign src_araddr  = gsrc ? s1.araddr  : s0.araddr;
    assign src_arvalid = gsrc ? s1.arvalid : s0.arvalid;
    assign src_rready  = gsrc ? s1.rready  : s0.rready;

    assign m.awvalid = in_w & src_awvalid & ~aw_done;
    assign m.awaddr  = m.awvalid ? src_awaddr : '0;
    assign m.wvalid  = in_w & src_wvalid & ~w_done;
    assign m.wdata   = m.wvalid ? src_wdata : '0;
    assign m.wstrb   = m.wvalid ? src_wstrb : '0;
    assign m.bready  = in_b & src_bready;
    assign m.arvalid = in_ar & src_arvalid;
    assign m.araddr  = m.arvalid ? src_araddr : '0;
    assign m.rready  = in_r & src_rready;

    assign awready_g = in_w & m.awready & ~aw_done;
    assign wready_g  = in_w & m.wready & ~w_done;
    assign bvalid_g  = in_b & m.bvalid;
    assign arready_g = in_ar & m.arready;
    assign rvalid_g  = in_r & m.rvalid;

    assign s0.awready = ~gsrc & awready_g;
    assign s0.wready  = ~gsrc & wready_g;
    assign s0.bvalid  = ~gsrc & bvalid_g;
    assign s0.bresp   = ~gsrc & in_b ? m.bresp : '0;
    assign s0.arready = ~gsrc & arready_g;
    assign s0.rvalid  = ~gsrc & rvalid_g;
    assign s0.rdata   = ~gsrc & in_r ? m.rdata : '0;
    assign s0.rresp   = ~gsrc & in_r ? m.rresp : '0;

    assign s1.awready = gsrc & awready_g;
    assign s1.wready  = gsrc & wready_g;
    assign s1.bvalid  = gsrc & bvalid_g;
    assign s1.bresp   = gsrc & in_b ? m.bresp : '0;
    assign s1.arready = gsrc & arready_g;
    assign s1.rvalid  = gsrc & rvalid_g;
    assign s1.rdata   = gsrc & in_r ? m.rdata : '0;
    assign s1.rresp   = gsrc & in_r ? m.rresp : '0;

    assign aw_hs = m.awvalid & m.awready;
    assign w_hs  = m.wvalid & m.wready;
    assign b_hs  = m.bready & m.bvalid;
    assign ar_hs = m.arvalid & m.arready;
    assign r_hs  = m.rready & m.rvalid;

    // Next state: grant only from IDLE, write waits for both aw and w in either order
    always_comb begin
        state_n = state;
        gsrc_n  = gsrc;
        awd_n   = aw_done | aw_hs;
        wd_n    = w_done | w_hs;
        upd     = 1'b0;
        case (state)
            IDLE: if (|req) begin
                upd     = 1'b1;
                gsrc_n  = g_src;
                state_n = g_rd ? RADDR : WADDR;
            end
            WADDR: if (awd_n && wd_n) begin
                state_n = WRESP;
                awd_n   = 1'b0;
                wd_n    = 1'b0;
            end
            WRESP: state_n = b_hs ? IDLE : WRESP;
            RADDR: state_n = ar_hs ? RDATA : RADDR;
            RDATA: state_n = r_hs ? IDLE : RDATA;
            default: state_n = IDLE;
        endcase
    end

    // State, granted source and write-channel completion flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gsrc    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_n;
            gsrc    <= gsrc_n;
            aw_done <= awd_n;
            w_done  <= wd_n;
        end
    end
endmodule

// File: tb/tb_axi_lite_arb_2x1.sv
// tb_axi_lite_arb_2x1: directed checks of grant order, write/read flows, async reset and candidate rules
module tb_axi_lite_arb_2x1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int tests = 0;
    int fails = 0;

    axi_lite_bus_t s0_if();
    axi_lite_bus_t s1_if();
    axi_lite_bus_t m_if();

    axi_lite_arb_2x1 #(.RD_FIRST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .s0(s0_if), .s1(s1_if), .m(m_if), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        s0_if.awaddr = '0; s0_if.awvalid = 0; s0_if.wdata = '0; s0_if.wstrb = '0; s0_if.wvalid = 0;
        s0_if.bready = 0; s0_if.araddr = '0; s0_if.arvalid = 0; s0_if.rready = 0;
        s1_if.awaddr = '0; s1_if.awvalid = 0; s1_if.wdata = '0; s1_if.wstrb = '0; s1_if.wvalid = 0;
        s1_if.bready = 0; s1_if.araddr = '0; s1_if.arvalid = 0; s1_if.rready = 0;
        m_if.awready = 0; m_if.wready = 0; m_if.bresp = '0; m_if.bvalid = 0;
        m_if.arready = 0; m_if.rdata = '0; m_if.rresp = '0; m_if.rvalid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_all();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        // Reset state with requests already pending
        clear_all();
        s0_if.awvalid = 1; s0_if.wvalid = 1; m_if.awready = 1; m_if.wready = 1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_m_awvalid", m_if.awvalid, 0);
        chk("rst_s0_awready", s0_if.awready, 0);
        do_reset();

        // s0 single write, target always ready
        s0_if.awaddr = 32'h10; s0_if.awvalid = 1; s0_if.wdata = 32'hA5A5A5A5; s0_if.wstrb = 4'hF;
        s0_if.wvalid = 1; s0_if.bready = 1; m_if.awready = 1; m_if.wready = 1;
        #1;
        chk("a_idle_awvalid", m_if.awvalid, 0);
        chk("a_idle_busy", busy, 0);
        step();
        chk("a_busy", busy, 1);
        chk("a_awvalid", m_if.awvalid, 1);
        chk("a_awaddr", m_if.awaddr, 32'h10);
        chk("a_wvalid", m_if.wvalid, 1);
        chk("a_wdata", m_if.wdata, 32'hA5A5A5A5);
        chk("a_wstrb", m_if.wstrb, 4'hF);
        chk("a_s0_awready", s0_if.awready, 1);
        chk("a_s0_wready", s0_if.wready, 1);
        chk("a_s1_awready", s1_if.awready, 0);
        step();
        s0_if.awvalid = 0; s0_if.wvalid = 0;
        #1;
        chk("a_resp_awvalid", m_if.awvalid, 0);
        chk("a_resp_awaddr", m_if.awaddr, 0);
        chk("a_bready", m_if.bready, 1);
        m_if.bvalid = 1; m_if.bresp = 2'b00;
        #1;
        chk("a_s0_bvalid", s0_if.bvalid, 1);
        chk("a_s0_bresp", s0_if.bresp, 0);
        chk("a_s1_bvalid", s1_if.bvalid, 0);
        step();
        m_if.bvalid = 0;
        chk("a_done_busy", busy, 0);

        // s0 write and s1 read together from reset
        do_reset();
        s0_if.awaddr = 32'h20; s0_if.awvalid = 1; s0_if.wdata = 32'h11111111; s0_if.wstrb = 4'hF;
        s0_if.wvalid = 1; s0_if.bready = 1;
        s1_if.araddr = 32'h44; s1_if.arvalid = 1; s1_if.rready = 1;
        m_if.awready = 1; m_if.wready = 1; m_if.arready = 1;
        step();
        chk("b_s0_awready", s0_if.awready, 1);
        chk("b_s1_arready", s1_if.arready, 0);
        chk("b_m_arvalid", m_if.arvalid, 0);
        step();
        s0_if.awvalid = 0; s0_if.wvalid = 0; m_if.bvalid = 1;
        step();
        m_if.bvalid = 0;
        chk("b_idle_busy", busy, 0);
        chk("b_idle_arvalid", m_if.arvalid, 0);
        step();
        chk("b_arvalid", m_if.arvalid, 1);
        chk("b_araddr", m_if.araddr, 32'h44);
        chk("b_s1_arready2", s1_if.arready, 1);
        chk("b_s0_arready", s0_if.arready, 0);
        step();
        s1_if.arvalid = 0; m_if.rvalid = 1; m_if.rdata = 32'hDEADBEEF; m_if.rresp = 2'b10;
        #1;
        chk("b_s1_rvalid", s1_if.rvalid, 1);
        chk("b_s1_rdata", s1_if.rdata, 32'hDEADBEEF);
        chk("b_s1_rresp", s1_if.rresp, 2'b10);
        chk("b_s0_rvalid", s0_if.rvalid, 0);
        chk("b_s0_rdata", s0_if.rdata, 0);
        step();
        m_if.rvalid = 0;
        chk("b_done_busy", busy, 0);

        // s1 write with wready three cycles ahead of awready
        clear_all();
        s1_if.awaddr = 32'h30; s1_if.awvalid = 1; s1_if.wdata = 32'h12345678; s1_if.wstrb = 4'h3;
        s1_if.wvalid = 1; s1_if.bready = 1; m_if.wready = 1;
        step();
        chk("c_wvalid", m_if.wvalid, 1);
        chk("c_wdata", m_if.wdata, 32'h12345678);
        chk("c_s1_wready", s1_if.wready, 1);
        chk("c_s1_awready", s1_if.awready, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("c_wait_wvalid", m_if.wvalid, 0);
            chk("c_wait_wdata", m_if.wdata, 0);
            chk("c_wait_awvalid", m_if.awvalid, 1);
        end
        step();
        m_if.awready = 1;
        #1;
        chk("c_s1_awready2", s1_if.awready, 1);
        chk("c_s1_wready2", s1_if.wready, 0);
        step();
        chk("c_resp_awvalid", m_if.awvalid, 0);
        chk("c_bready", m_if.bready, 1);
        s1_if.awvalid = 0; s1_if.wvalid = 0; m_if.bvalid = 1; m_if.bresp = 2'b10;
        #1;
        chk("c_s1_bvalid", s1_if.bvalid, 1);
        chk("c_s1_bresp", s1_if.bresp, 2'b10);
        chk("c_s0_bvalid", s0_if.bvalid, 0);
        step();
        m_if.bvalid = 0;
        chk("c_done_busy", busy, 0);

        // Continuous traffic on all four slots: ring order 0W,0R,1W,1R
        do_reset();
        s0_if.awvalid = 1; s0_if.wvalid = 1; s0_if.arvalid = 1; s0_if.bready = 1; s0_if.rready = 1;
        s1_if.awvalid = 1; s1_if.wvalid = 1; s1_if.arvalid = 1; s1_if.bready = 1; s1_if.rready = 1;
        m_if.awready = 1; m_if.wready = 1; m_if.arready = 1; m_if.bvalid = 1; m_if.rvalid = 1;
        for (int g = 0; g < 40; g++) begin
            step();
            chk("d_slot", {30'd0, s1_if.awready | s1_if.arready, m_if.arvalid}, g % 4);
            step();
            step();
        end

        // Async reset during RDATA, then slot 0 wins again
        clear_all();
        s0_if.araddr = 32'h50; s0_if.arvalid = 1; m_if.arready = 1;
        step();
        step();
        s0_if.arvalid = 0; m_if.rvalid = 1; m_if.rdata = 32'hCAFEF00D;
        #1;
        chk("e_s0_rvalid", s0_if.rvalid, 1);
        chk("e_busy", busy, 1);
        rst_n = 0;
        #1;
        chk("e_rst_rvalid", s0_if.rvalid, 0);
        chk("e_rst_rdata", s0_if.rdata, 0);
        chk("e_rst_busy", busy, 0);
        #1 rst_n = 1;
        m_if.rvalid = 0;
        s0_if.awvalid = 1; s0_if.wvalid = 1; s1_if.arvalid = 1;
        m_if.awready = 1; m_if.wready = 1;
        step();
        chk("e_s0_awready", s0_if.awready, 1);
        chk("e_s1_arready", s1_if.arready, 0);

        // Lone awvalid on s0 is never a candidate while s1 reads
        do_reset();
        s0_if.awaddr = 32'h70; s0_if.awvalid = 1;
        s1_if.araddr = 32'h80; s1_if.arvalid = 1; s1_if.rready = 1;
        m_if.arready = 1; m_if.awready = 1; m_if.wready = 1; m_if.rvalid = 1; m_if.rdata = 32'h0BADF00D;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("f_s0_awready", s0_if.awready, 0);
            chk("f_m_awvalid", m_if.awvalid, 0);
            chk("f_m_arvalid", m_if.arvalid, k % 3 == 1);
            chk("f_s1_rvalid", s1_if.rvalid, k % 3 == 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
